// File: rtl/flash_buf_program.sv
// flash_buf_program: buffered-program sequencer for the parallel NOR flash.
// On prog_en it runs clear-status, buffered-program setup with ready polling,
// word count, data words pulled from an upstream FIFO, confirm, completion
// polling and a final return to read-array mode. Every flash access is one
// wr_*/rd_* command to the bus controller, with at most one outstanding.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   prog_en/prog_addr/prog_length start pulse, first word address, word count
//   prog_data_req/prog_data      FIFO pull pulse, word valid one cycle later
//   busy/prog_done/prog_err/prog_status  status; err/status held until next start
//   wr_en/wr_addr/wr_data/wr_done         single-word write command
//   rd_en/rd_addr/rd_length/rd_data/rd_valid/rd_done  read command
//
// Optional feature: define FLASH_PROG_TIMEOUT_EN to bound each poll phase to
// POLL_MAX status reads; without it polling is unbounded.
module flash_buf_program #(
  parameter int BUF_WORDS = 512,
  parameter int POLL_MAX  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_en,
  input  logic [24:0] prog_addr,
  input  logic [9:0]  prog_length,
  output logic        prog_data_req,
  input  logic [15:0] prog_data,
  output logic        busy,
  output logic        prog_done,
  output logic        prog_err,
  output logic [7:0]  prog_status,
  output logic        wr_en,
  output logic [24:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_done,
  output logic        rd_en,
  output logic [24:0] rd_addr,
  output logic [16:0] rd_length,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  input  logic        rd_done
);
  localparam int LB = $clog2(BUF_WORDS);

  typedef enum logic [3:0] {
    IDLE, CHECK, CLR_SR, SETUP, POLL_BUF, WCOUNT, WDATA,
    CONFIRM, POLL_DONE, EVAL, READ_ARRAY, DONE
  } state_t;

  state_t      state, cmd_next;
  logic [1:0]  ph;        // sub-step inside a state: 0 = issue, then wait
  logic [24:0] a;
  logic [9:0]  len, idx;
  logic [7:0]  sr, sr_now;
  logic [15:0] cmd_word;
  logic        param_bad;

`ifdef FLASH_PROG_TIMEOUT_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic [PW-1:0] poll_cnt;
  logic          unused_ok;
  assign unused_ok = ^rd_data[15:8];
`else
  logic          unused_ok;
  assign unused_ok = ^rd_data[15:8] ^ (^POLL_MAX);
`endif

  // rd_valid and rd_done may coincide, so decide on the live byte then.
  assign sr_now = rd_valid ? rd_data[7:0] : sr;

  assign param_bad = (len == '0) || (32'(len) > 32'(BUF_WORDS)) ||
                     ((32'(a[LB-1:0]) + 32'(len)) > 32'(BUF_WORDS));

  // Command word and successor for the plain single-write states.
  always_comb begin
    cmd_word = '0;
    cmd_next = IDLE;
    case (state)
      CLR_SR:     begin cmd_word = 16'h0050;            cmd_next = SETUP;     end
      SETUP:      begin cmd_word = 16'h00E8;            cmd_next = POLL_BUF;  end
      WCOUNT:     begin cmd_word = 16'(len - 10'd1);    cmd_next = WDATA;     end
      CONFIRM:    begin cmd_word = 16'h00D0;            cmd_next = POLL_DONE; end
      READ_ARRAY: begin cmd_word = 16'h00FF;            cmd_next = DONE;      end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ph            <= '0;
      a             <= '0;
      len           <= '0;
      idx           <= '0;
      sr            <= '0;
      busy          <= 1'b0;
      prog_done     <= 1'b0;
      prog_err      <= 1'b0;
      prog_status   <= '0;
      prog_data_req <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      rd_length     <= '0;
`ifdef FLASH_PROG_TIMEOUT_EN
      poll_cnt      <= '0;
`endif
    end else begin
      // Pulses and command fields are zero unless set below for one cycle.
      prog_done     <= 1'b0;
      prog_data_req <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      rd_length     <= '0;
      if (rd_valid && (state == POLL_BUF || state == POLL_DONE)) sr <= rd_data[7:0];

      case (state)
        // busy is already low in DONE, so a start is accepted there too.
        IDLE, DONE: begin
          if (prog_en) begin
            a           <= prog_addr;
            len         <= prog_length;
            prog_err    <= 1'b0;
            prog_status <= '0;
            busy        <= 1'b1;
            idx         <= '0;
            ph          <= '0;
            state       <= CHECK;
          end else begin
            state <= IDLE;
          end
        end
        CHECK: begin
          if (param_bad) begin
            prog_err  <= 1'b1;
            prog_done <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            state <= CLR_SR;
          end
        end
        CLR_SR, SETUP, WCOUNT, CONFIRM, READ_ARRAY: begin
`ifdef FLASH_PROG_TIMEOUT_EN
          if (state == CLR_SR || state == CONFIRM) poll_cnt <= '0;
`endif
          if (ph == 2'd0) begin
            wr_en   <= 1'b1;
            wr_addr <= a;
            wr_data <= cmd_word;
            ph      <= 2'd1;
          end else if (wr_done) begin
            ph    <= 2'd0;
            state <= cmd_next;
            if (cmd_next == DONE) begin
              prog_done <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        // Per word: pull, wait one cycle for FIFO data, write, wait done.
        WDATA: begin
          case (ph)
            2'd0: begin prog_data_req <= 1'b1; ph <= 2'd1; end
            2'd1: ph <= 2'd2;
            2'd2: begin
              wr_en   <= 1'b1;
              wr_addr <= a + 25'(idx);
              wr_data <= prog_data;
              ph      <= 2'd3;
            end
            default: begin
              if (wr_done) begin
                ph <= 2'd0;
                if (idx + 10'd1 == len) begin
                  idx   <= '0;
                  state <= CONFIRM;
                end else begin
                  idx <= idx + 10'd1;
                end
              end
            end
          endcase
        end
        POLL_BUF, POLL_DONE: begin
          if (ph == 2'd0) begin
            rd_en     <= 1'b1;
            rd_addr   <= a;
            rd_length <= 17'd1;
            ph        <= 2'd1;
          end else if (rd_done) begin
            ph <= 2'd0;
`ifdef FLASH_PROG_TIMEOUT_EN
            poll_cnt <= poll_cnt + PW'(1);
`endif
            if (sr_now[7])
              state <= (state == POLL_BUF) ? WCOUNT : EVAL;
`ifdef FLASH_PROG_TIMEOUT_EN
            else if (poll_cnt + PW'(1) == PW'(POLL_MAX)) begin
              prog_err    <= 1'b1;
              prog_status <= sr_now;
              state       <= READ_ARRAY;
            end
`endif
            else
              state <= (state == POLL_BUF) ? SETUP : POLL_DONE;
          end
        end
        EVAL: begin
          prog_status <= sr;
          prog_err    <= |(sr & 8'h3A);
          state       <= READ_ARRAY;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_buf_program.sv
// Bench for flash_buf_program: randomized bus/FIFO responders, a transaction
// level model that expands each request into its expected command list, and
// one per-cycle compare process checking outputs against that model.
module tb_flash_buf_program;
`ifdef FLASH_PROG_TIMEOUT_EN
  localparam int PM = 8;
`else
  localparam int PM = 65535;
`endif

  logic        clk, rst_n, prog_en, prog_data_req, busy, prog_done, prog_err;
  logic [24:0] prog_addr, wr_addr, rd_addr;
  logic [9:0]  prog_length;
  logic [15:0] prog_data, wr_data, rd_data;
  logic [7:0]  prog_status;
  logic        wr_en, wr_done, rd_en, rd_valid, rd_done;
  logic [16:0] rd_length;

  flash_buf_program #(.BUF_WORDS(512), .POLL_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_addr(prog_addr),
    .prog_length(prog_length), .prog_data_req(prog_data_req), .prog_data(prog_data),
    .busy(busy), .prog_done(prog_done), .prog_err(prog_err), .prog_status(prog_status),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_length(rd_length), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_done(rd_done));

  initial begin clk = 0; forever #5 clk = ~clk; end

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit outs_nz();
    return busy | prog_done | prog_err | (|prog_status) | prog_data_req | wr_en |
           (|wr_addr) | (|wr_data) | rd_en | (|rd_addr) | (|rd_length);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {bit rd; bit dat; int dly; logic [24:0] addr; logic [15:0] val;} op_t;
  op_t         exp_q[$];
  logic [7:0]  plan[$];    // status bytes returned by successive reads
  logic [7:0]  sr_q[$];
  logic [15:0] dat[512];
  bit          exp_reject;
  logic        exp_err_v, held_err;
  logic [7:0]  exp_stat_v, held_stat;

  function automatic void push_op(bit rd, bit dt, int dly, logic [24:0] ad, logic [15:0] v);
    op_t o;
    o.rd = rd; o.dat = dt; o.dly = dly; o.addr = ad; o.val = v;
    exp_q.push_back(o);
  endfunction

  // dly: cycles from the reference event (accept for the first command,
  // FIFO pull for data words, previous done otherwise) to the enable.
  task automatic build(input logic [24:0] a, input int len);
    int k = 0, n;
    logic [7:0] s = 8'h00;
    bit tmo = 0;
    exp_q.delete();
    exp_reject = (len == 0) || (len > 512) || (int'(a % 25'd512) + len > 512);
    if (exp_reject) begin exp_err_v = 1; exp_stat_v = 0; return; end
    push_op(0, 0, 3, a, 16'h0050);
    n = 0;
    while (1) begin
      push_op(0, 0, 2, a, 16'h00E8);
      push_op(1, 0, 2, a, 16'h0000);
      s = (k < plan.size()) ? plan[k] : 8'h80; k++; n++;
      if (s[7]) break;
      if (n == PM) begin tmo = 1; break; end
    end
    if (!tmo) begin
      push_op(0, 0, 2, a, 16'(len - 1));
      for (int i = 0; i < len; i++) push_op(0, 1, 2, a + 25'(i), dat[i]);
      push_op(0, 0, 2, a, 16'h00D0);
      n = 0;
      while (1) begin
        push_op(1, 0, 2, a, 16'h0000);
        s = (k < plan.size()) ? plan[k] : 8'h80; k++; n++;
        if (s[7]) break;
        if (n == PM) begin tmo = 1; break; end
      end
    end
    exp_stat_v = s;
    exp_err_v  = tmo ? 1'b1 : (|(s & 8'h3A));
    // a normal completion passes through one evaluation cycle first
    push_op(0, 0, tmo ? 2 : 3, a, 16'h00FF);
  endtask

  // ---------------- bus controller responder ----------------
  int pend;
  bit brd, split;
  logic [7:0] sv;
  initial begin
    pend = 0; brd = 0; split = 0; sv = 0;
    wr_done = 0; rd_done = 0; rd_valid = 0; rd_data = 0;
    forever begin
      @(posedge clk); #1;
      wr_done = 0; rd_done = 0; rd_valid = 0; rd_data = 16'($urandom);
      if (!rst_n) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (brd && split && pend == 1) begin rd_valid = 1; rd_data = {8'($urandom), sv}; end
        if (pend == 0) begin
          if (brd) begin
            rd_done = 1;
            if (!split) begin rd_valid = 1; rd_data = {8'($urandom), sv}; end
          end else wr_done = 1;
        end
      end else if (wr_en || rd_en) begin
        brd = rd_en;
        split = 1'($urandom_range(0, 1));
        pend = $urandom_range(split ? 2 : 1, 4);
        if (rd_en) begin
          if (sr_q.size() > 0) sv = sr_q.pop_front(); else sv = 8'h80;
        end
      end
    end
  end

  // ---------------- upstream FIFO ----------------
  int fifo_idx;
  bit req_seen;
  initial begin
    prog_data = 0; req_seen = 0; fifo_idx = 0;
    forever begin
      @(posedge clk); #1;
      if (req_seen) begin prog_data = dat[fifo_idx & 511]; fifo_idx++; end
      else prog_data = 16'($urandom);
      req_seen = prog_data_req && rst_n;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit   exp_busy = 0, outst = 0, first = 0;
  int   t_acc = 0, last_done = 0, last_req = 0, done_cnt = 0, done_cyc = 0;
  int   n_wr = 0, n_rd = 0, n_e8 = 0, n_data = 0;
  logic [15:0] last_wval = 0;
  op_t  me;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs_zero", 32'(outs_nz()), 0);
      exp_busy = 0; outst = 0; exp_q.delete(); held_err = 0; held_stat = 0;
    end else begin
      chk("busy", 32'(busy), prog_done ? 0 : 32'(exp_busy));
      if (!wr_en) chk("wr_fields_idle", 32'((|wr_addr) | (|wr_data)), 0);
      if (!rd_en) chk("rd_fields_idle", 32'((|rd_addr) | (|rd_length)), 0);
      if (!exp_busy && !prog_done) begin
        chk("err_held", 32'(prog_err), 32'(held_err));
        chk("status_held", 32'(prog_status), 32'(held_stat));
      end
      if (prog_data_req) begin
        chk("req_timing", cyc, last_done + 2);
        chk("req_with_cmd_open", 32'(outst), 0);
        last_req = cyc;
      end
      if (wr_en || rd_en) begin
        chk("single_enable", 32'(wr_en & rd_en), 0);
        chk("cmd_overlap", 32'(outst), 0);
        chk("cmd_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          me = exp_q.pop_front();
          chk("cmd_kind", 32'(rd_en), 32'(me.rd));
          chk("cmd_addr", 32'(wr_en ? wr_addr : rd_addr), 32'(me.addr));
          if (wr_en) chk("wr_data", 32'(wr_data), 32'(me.val));
          if (rd_en) chk("rd_length", 32'(rd_length), 1);
          chk("cmd_timing", cyc, (first ? t_acc : (me.dat ? last_req : last_done)) + me.dly);
          if (me.dat) n_data++;
          else if (wr_en && wr_data == 16'h00E8) n_e8++;
        end
        if (wr_en) begin n_wr++; last_wval = wr_data; end
        if (rd_en) n_rd++;
        first = 0; outst = 1;
      end
      if (wr_done || rd_done) begin outst = 0; last_done = cyc; end
      if (prog_done) begin
        chk("done_when_busy", 32'(exp_busy), 1);
        chk("done_cmds_left", exp_q.size(), 0);
        chk("done_err", 32'(prog_err), 32'(exp_err_v));
        chk("done_status", 32'(prog_status), 32'(exp_stat_v));
        if (exp_reject) chk("reject_latency", cyc - t_acc, 2);
        held_err = exp_err_v; held_stat = exp_stat_v;
        exp_busy = 0; done_cyc = cyc; done_cnt++;
      end
      if (prog_en && !exp_busy) begin
        t_acc = cyc; first = 1; exp_busy = 1;
        n_wr = 0; n_rd = 0; n_e8 = 0; n_data = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start(input logic [24:0] a, input int len);
    sr_q = plan;
    fifo_idx = 0;
    build(a, len);
    @(posedge clk); #1;
    prog_addr = a; prog_length = 10'(len); prog_en = 1;
    @(posedge clk); #1;
    prog_en = 0; prog_addr = 25'($urandom); prog_length = 10'($urandom);
  endtask

  task automatic run(input logic [24:0] a, input int len, input bit stray);
    int d0 = done_cnt;
    start(a, len);
    for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      prog_en = (stray && busy && $urandom_range(0, 5) == 0);
    end
    prog_en = 0;
    chk("done_seen", done_cnt - d0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic nominal_data();
    dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333; dat[3] = 16'h4444;
  endtask

  initial begin
    rst_n = 0; prog_en = 0; prog_addr = 0; prog_length = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(outs_nz()), 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    // nominal
    plan.delete(); nominal_data();
    begin
      int d0 = done_cnt;
      start(25'h000100, 4);
      chk("model_op_count", exp_q.size(), 11);
      for (int i = 0; i < 4000 && done_cnt == d0; i++) begin @(posedge clk); #1; end
      chk("nominal_done", done_cnt - d0, 1);
    end
    chk("nominal_err", 32'(prog_err), 0);
    chk("nominal_status", 32'(prog_status), 32'h80);
    chk("nominal_writes", n_wr, 9);
    chk("nominal_reads", n_rd, 2);
    chk("nominal_last_write", 32'(last_wval), 32'h00FF);

    // buffer not ready twice
    plan = '{8'h00, 8'h00, 8'h80};
    run(25'h000100, 4, 0);
    chk("setup_retries", n_e8, 3);

    // program failure
    plan = '{8'h80, 8'h90};
    run(25'h000100, 4, 0);
    chk("fail_err", 32'(prog_err), 1);
    chk("fail_status", 32'(prog_status), 32'h90);
    chk("fail_read_array", 32'(last_wval), 32'h00FF);

    // parameter rejects
    plan.delete();
    run(25'h000100, 0, 0);
    chk("len0_traffic", n_wr + n_rd, 0);
    chk("len0_latency", done_cyc - t_acc, 2);
    run(25'h000000, 513, 0);
    chk("len513_traffic", n_wr + n_rd, 0);
    chk("len513_err", 32'(prog_err), 1);
    run(25'h0001FF, 2, 0);
    chk("cross_traffic", n_wr + n_rd, 0);
    chk("cross_latency", done_cyc - t_acc, 2);

    // reset while word 2 is being fetched, then a clean nominal run
    plan.delete(); nominal_data();
    begin
      bit hit = 0;
      start(25'h000100, 4);
      for (int i = 0; i < 500 && !hit; i++) begin
        @(posedge clk); #1;
        hit = (n_data == 2) && prog_data_req;
      end
      chk("reset_point_reached", 32'(hit), 1);
      rst_n = 0; #1;
      chk("async_reset_outputs", 32'(outs_nz()), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
    end
    nominal_data();
    run(25'h000100, 4, 0);
    chk("post_reset_writes", n_wr, 9);
    chk("post_reset_status", 32'(prog_status), 32'h80);

`ifdef FLASH_PROG_TIMEOUT_EN
    plan = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run(25'h000100, 4, 0);
    chk("timeout_reads", n_rd, 9);
    chk("timeout_err", 32'(prog_err), 1);
    chk("timeout_status", 32'(prog_status), 0);
    chk("timeout_read_array", 32'(last_wval), 32'h00FF);
`endif

    // randomized traffic with stray starts while busy
    for (int t = 0; t < 24; t++) begin
      int len, off, r, kb, kd;
      logic [24:0] a;
      plan.delete();
      kb = $urandom_range(0, 2);
      repeat (kb) plan.push_back(8'($urandom) & 8'h7F);
      plan.push_back(8'h80 | 8'($urandom));
      kd = $urandom_range(0, 2);
      repeat (kd) plan.push_back(8'($urandom) & 8'h7F);
      plan.push_back(8'h80 | (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00));
      for (int i = 0; i < 512; i++) dat[i] = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) begin len = 0; off = $urandom_range(0, 511); end
      else if (r == 1) begin len = $urandom_range(513, 700); off = 0; end
      else if (r == 2) begin off = $urandom_range(500, 511); len = 512 - off + $urandom_range(1, 4); end
      else begin len = $urandom_range(1, 12); off = $urandom_range(0, 512 - len); end
      a = (25'($urandom) & ~25'h1FF) | 25'(off);
      run(a, len, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
